add_accu: RTL and testbench
===========================

# add_accu

Downstream consumer of the pipelined multi-input adder tree in the MVU datapath. Accumulates successive partial sums of one output channel across the fold (SF) dimension, closes each dot product on a fold count or an explicit last flag, and queues finished results in a small output FIFO with a valid/ready stream interface. Upstream back-pressure goes out through `in_ready`.

## Interface
Parameters:
- `SUM_WIDTH`, 16: width of the incoming adder-tree sum.
- `ACCU_WIDTH`, 32: accumulator and result width. Must be at least `SUM_WIDTH`; elaboration error otherwise.
- `SIGNED`, 1: 1 sign-extends `in_sum`, 0 zero-extends it.
- `FOLD`, 4: number of beats per result. 0 means results close on `in_last` only.
- `FIFO_DEPTH`, 4: result FIFO entries, at least 2.

Ports:
- `clk`  in  1  the single clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_sum` holds a valid partial sum.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_sum`  in  `SUM_WIDTH`  partial sum from the adder tree.
- `in_last`  in  1  final beat of a dot product. Used only when `FOLD == 0`.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_data`  out  `ACCU_WIDTH`  finished accumulation.
- `out_sat`  out  1  the head result saturated at least once. Tied to 0 without the macro.

## Operation
- **Accept.** A beat is accepted when `in_valid && in_ready`.
- **Ready rule.** `in_ready = (count < FIFO_DEPTH)`. It is combinational from registered `count` only, never from `out_ready`. Non-last beats are held off as well as last beats while the FIFO is full.
- **State registers:**
  - `acc` (`ACCU_WIDTH` bits), reset 0.
  - `first`, reset 1.
  - `beat`, a fold counter of `$clog2(FOLD+1)` bits, reset 0.
  - `sat_acc`, reset 0.
- **Extension.** `ext = SIGNED ? sext(in_sum) : zext(in_sum)`.
- **Next value on an accepted beat.** `nxt = (first ? 0 : acc) + ext`.
  - Without the macro, `nxt` wraps modulo 2^`ACCU_WIDTH`.
- **Close condition.**
  - `FOLD > 0`: close when `beat == FOLD-1`. `in_last` is ignored.
  - `FOLD == 0`: close when `in_last`.
- **Accepted beat, no close:** `acc <= nxt`, `first <= 0`, `beat <= beat+1`.
- **Accepted beat, close:**
  - push `{nxt, sat}` into the FIFO;
  - `first <= 1`, `beat <= 0`, `sat_acc <= 0`;
  - `acc` is don't-care.
- **`FOLD == 1`:** every beat closes, and the result equals `ext`.
- **FIFO.** A circular buffer with `wr`/`rd` pointers that wrap at `FIFO_DEPTH`, plus an occupancy `count`.
  - A pop occurs on `out_valid && out_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - A push cannot happen while full, because `in_ready` is low.
  - A pop while empty is impossible, because `out_valid` is low.
- **Outputs.** `out_valid = (count != 0)`. `out_data` and `out_sat` are driven from the head entry.
- **Reset mid-operation.** Discards the partial accumulation and all FIFO contents immediately. The next accepted beat starts a new dot product.

## Timing
- **Reset values:**
  - `out_valid` 0, `out_data` 0, `out_sat` 0;
  - `in_ready` 1 (`count` 0);
  - all internal state as listed under Operation.
- **Latency.** A closing beat accepted in cycle t makes `out_valid` high in cycle t+1 when the FIFO was empty. There is no combinational path from `in_*` to `out_*`.
- **Throughput.** One beat per cycle while `out_ready` is held high.
- **Full to not-full.** A pop in cycle t with `count == FIFO_DEPTH` raises `in_ready` in cycle t+1.
- **Stream stability.** While `out_valid && !out_ready`, `out_data` and `out_sat` stay stable. Upstream must hold `in_sum` and `in_last` while `in_valid && !in_ready`.

## Configuration
- **Macro:** `ADD_ACCU_SAT_EN`.
- **Defined:** `nxt` saturates instead of wrapping.
  - Signed range: [-2^(`ACCU_WIDTH`-1), 2^(`ACCU_WIDTH`-1)-1].
  - Unsigned range: [0, 2^`ACCU_WIDTH`-1].
  - Any clamp sets `sat_acc`.
  - The pushed `sat` is `sat_acc` OR the clamp on the closing beat.
- **Undefined:** arithmetic wraps, no saturation logic is built, and `out_sat` is constant 0.

## Test plan
- **Basic fold.** Reset, then `FOLD=4`, `SIGNED=1`, `out_ready=1`, sums 3, -1, 7, 2 on consecutive cycles. Required: one result of 11, with `out_valid` high exactly one cycle after the 4th beat. `in_ready` stays high throughout.
- **Last-flag closing.** `FOLD=0`, sums 5, 5, 5 with `in_last` on the 3rd, then sum 9 with `in_last`. Required: results 15 then 9, in order.
- **Back-pressure and full FIFO.** `FIFO_DEPTH=4`, `FOLD=1`, `out_ready=0`, 6 beats of values 1..6.
  - `in_ready` drops after 4 accepted beats, and beats 5 and 6 are held.
  - Then `out_ready=1`: outputs 1..6 appear in order, and `in_ready` rises the cycle after the first pop.
- **Unsigned extension.** `SIGNED=0`, `SUM_WIDTH=16`, `FOLD=2`, sums 0xFFFF, 0x0001. Required: result 0x00010000.
- **Wrap versus saturation.** `ACCU_WIDTH=16`, `SUM_WIDTH=16`, `FOLD=2`, sums 0x7FFF, 0x0001.
  - Without the macro: result 0x8000, `out_sat=0`.
  - With `ADD_ACCU_SAT_EN`: result 0x7FFF, `out_sat=1`.
- **Reset mid-operation.** `FOLD=4`, 2 beats of value 10, plus 2 results left queued in the FIFO, then `rst_n` low for one cycle.
  - Required: `out_valid` drops immediately.
  - After reset, 4 beats of value 1 give a result of 4 (no leftover 20).

Source files
------------

// File: rtl/add_accu.sv
// add_accu: accumulates successive adder-tree partial sums of one output channel
// over the fold dimension and queues each finished dot product in a small result FIFO.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake; in_ready depends only on FIFO occupancy
//   in_sum                partial sum (sign- or zero-extended per SIGNED)
//   in_last               closes a dot product when FOLD == 0, otherwise ignored
//   out_valid/out_ready   result stream handshake
//   out_data, out_sat     FIFO head: result and its saturation flag
//
// Optional feature macro: ADD_ACCU_SAT_EN. When defined, accumulation saturates and
// out_sat reports clamping. When undefined, accumulation wraps and out_sat is 0.
module add_accu #(
   parameter int unsigned SUM_WIDTH  = 16,
   parameter int unsigned ACCU_WIDTH = 32,
   parameter bit          SIGNED     = 1'b1,
   parameter int unsigned FOLD       = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SUM_WIDTH-1:0]  in_sum,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACCU_WIDTH-1:0] out_data,
   output logic                  out_sat
);

   if (ACCU_WIDTH < SUM_WIDTH) begin : g_bad_width
      $error("add_accu: ACCU_WIDTH must be at least SUM_WIDTH");
   end
   if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("add_accu: FIFO_DEPTH must be at least 2");
   end

   localparam int unsigned BeatW = (FOLD > 0) ? $clog2(FOLD + 1) : 1;
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
   localparam logic [BeatW-1:0] BeatLast = BeatW'((FOLD > 0) ? FOLD - 1 : 0);

   logic [ACCU_WIDTH-1:0] acc_q, acc_d;
   logic                  first_q, first_d;
   logic [BeatW-1:0]      beat_q, beat_d;
   logic [PtrW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [ACCU_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [ACCU_WIDTH-1:0] mem_d [FIFO_DEPTH];

   logic [ACCU_WIDTH-1:0] ext, base, nxt;
   logic                  accept, close, push, pop;

   assign in_ready  = (count_q < CntW'(FIFO_DEPTH));
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[rd_q];

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;
   assign close  = (FOLD == 0) ? in_last : (beat_q == BeatLast);
   assign push   = accept && close;
   assign base   = first_q ? '0 : acc_q;

   always_comb begin
      ext = ACCU_WIDTH'(in_sum);
      if (SIGNED) ext = ACCU_WIDTH'($signed(in_sum));
   end

`ifdef ADD_ACCU_SAT_EN
   logic                  sat_acc_q, sat_acc_d;
   logic                  sat_mem_q [FIFO_DEPTH];
   logic                  sat_mem_d [FIFO_DEPTH];
   logic [ACCU_WIDTH:0]   wide;
   logic                  clamp;

   // One extra bit exposes overflow; clamp to the range limit on the overflow side.
   always_comb begin
      if (SIGNED) begin
         wide  = {base[ACCU_WIDTH-1], base} + {ext[ACCU_WIDTH-1], ext};
         clamp = wide[ACCU_WIDTH] ^ wide[ACCU_WIDTH-1];
         nxt   = wide[ACCU_WIDTH-1:0];
         if (clamp) nxt = wide[ACCU_WIDTH] ? {1'b1, {(ACCU_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACCU_WIDTH-1){1'b1}}};
      end else begin
         wide  = {1'b0, base} + {1'b0, ext};
         clamp = wide[ACCU_WIDTH];
         nxt   = clamp ? '1 : wide[ACCU_WIDTH-1:0];
      end
   end

   always_comb begin
      sat_acc_d = sat_acc_q;
      sat_mem_d = sat_mem_q;
      if (accept) sat_acc_d = close ? 1'b0 : (sat_acc_q | clamp);
      if (push) sat_mem_d[wr_q] = sat_acc_q | clamp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_acc_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) sat_mem_q[i] <= 1'b0;
      end else begin
         sat_acc_q <= sat_acc_d;
         sat_mem_q <= sat_mem_d;
      end
   end

   assign out_sat = sat_mem_q[rd_q];
`else
   assign nxt     = base + ext;
   assign out_sat = 1'b0;
`endif

   always_comb begin
      acc_d   = acc_q;
      first_d = first_q;
      beat_d  = beat_q;
      if (accept) begin
         if (close) begin
            first_d = 1'b1;
            beat_d  = '0;
         end else begin
            acc_d   = nxt;
            first_d = 1'b0;
            beat_d  = beat_q + 1'b1;
         end
      end
   end

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push) begin
         mem_d[wr_q] = nxt;
         wr_d = (wr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_d = (rd_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         first_q <= 1'b1;
         beat_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         acc_q   <= acc_d;
         first_q <= first_d;
         beat_q  <= beat_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: tb/tb_add_accu.sv
// Bench for add_accu: six differently configured instances, each with its own stream
// inputs, checked every cycle against a plain-arithmetic model of the accumulation rules.
module tb_add_accu;

   localparam int ND = 6;
   localparam int AW [ND] = '{32, 32, 32, 32, 16, 16};
   localparam int SG [ND] = '{1, 1, 1, 0, 1, 0};
   localparam int FD [ND] = '{4, 0, 1, 2, 2, 3};
   localparam int DP [ND] = '{4, 4, 4, 4, 4, 2};
`ifdef ADD_ACCU_SAT_EN
   localparam bit SatEn = 1'b1;
`else
   localparam bit SatEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv [ND];
   logic [15:0] isum [ND];
   logic        ilast [ND];
   logic        ordy [ND];
   logic        ir [ND];
   logic        ov [ND];
   logic        os [ND];
   logic [31:0] od [ND];
   logic [31:0] od0, od1, od2, od3;
   logic [15:0] od4, od5;

   always #5 clk = ~clk;

   always_comb begin
      od[0] = od0; od[1] = od1; od[2] = od2; od[3] = od3;
      od[4] = {16'h0, od4}; od[5] = {16'h0, od5};
   end

   add_accu #(.SUM_WIDTH(16), .ACCU_WIDTH(32), .SIGNED(1'b1), .FOLD(4), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_sum(isum[0]),
      .in_last(ilast[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
      .out_sat(os[0]));
   add_accu #(.SUM_WIDTH(16), .ACCU_WIDTH(32), .SIGNED(1'b1), .FOLD(0), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_sum(isum[1]),
      .in_last(ilast[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
      .out_sat(os[1]));
   add_accu #(.SUM_WIDTH(16), .ACCU_WIDTH(32), .SIGNED(1'b1), .FOLD(1), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_sum(isum[2]),
      .in_last(ilast[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2),
      .out_sat(os[2]));
   add_accu #(.SUM_WIDTH(16), .ACCU_WIDTH(32), .SIGNED(1'b0), .FOLD(2), .FIFO_DEPTH(4)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_sum(isum[3]),
      .in_last(ilast[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od3),
      .out_sat(os[3]));
   add_accu #(.SUM_WIDTH(16), .ACCU_WIDTH(16), .SIGNED(1'b1), .FOLD(2), .FIFO_DEPTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .in_sum(isum[4]),
      .in_last(ilast[4]), .out_valid(ov[4]), .out_ready(ordy[4]), .out_data(od4),
      .out_sat(os[4]));
   add_accu #(.SUM_WIDTH(16), .ACCU_WIDTH(16), .SIGNED(1'b0), .FOLD(3), .FIFO_DEPTH(2)) u5 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[5]), .in_ready(ir[5]), .in_sum(isum[5]),
      .in_last(ilast[5]), .out_valid(ov[5]), .out_ready(ordy[5]), .out_data(od5),
      .out_sat(os[5]));

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input int i, input logic [63:0] got,
                      input logic [63:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s dut%0d: got %0h, want %0h at %0t", nm, i, got, want, $time);
      end
   endtask

   // Model state: accumulation as a true integer, result queue of finished values.
   longint acc_m [ND];
   bit     first_m [ND];
   int     beat_m [ND];
   bit     sat_m [ND];
   bit     took [ND];
   longint qd [ND][$];
   bit     qs [ND][$];
   longint logd [ND][$];
   bit     logs [ND][$];

   function automatic longint mask_of(input int i);
      return (longint'(1) << AW[i]) - 1;
   endfunction

   task automatic model_beat(input int i);
      longint ext, s, lo, hi;
      bit     clamp, close, satf;
      ext   = SG[i] ? longint'($signed(isum[i])) : longint'(isum[i]);
      s     = (first_m[i] ? 64'sd0 : acc_m[i]) + ext;
      lo    = SG[i] ? -(longint'(1) << (AW[i] - 1)) : 0;
      hi    = SG[i] ? (longint'(1) << (AW[i] - 1)) - 1 : mask_of(i);
      clamp = 1'b0;
      if (SatEn) begin
         if (s > hi) begin s = hi; clamp = 1'b1; end
         if (s < lo) begin s = lo; clamp = 1'b1; end
      end else begin
         s = s & mask_of(i);
         if (SG[i] != 0 && s > hi) s = s - (longint'(1) << AW[i]);
      end
      close = (FD[i] > 0) ? (beat_m[i] == FD[i] - 1) : ilast[i];
      satf  = sat_m[i] | clamp;
      if (close) begin
         qd[i].push_back(s);
         qs[i].push_back(satf);
         first_m[i] = 1'b1; beat_m[i] = 0; sat_m[i] = 1'b0;
      end else begin
         acc_m[i] = s; first_m[i] = 1'b0; beat_m[i]++; sat_m[i] = satf;
      end
   endtask

   // Compare process: outputs against model, then advance model across the coming edge.
   always @(negedge clk) begin
      for (int i = 0; i < ND; i++) begin
         if (!rst_n) begin
            chk("rst_out_valid", i, 64'(ov[i]), 64'd0);
            chk("rst_in_ready", i, 64'(ir[i]), 64'd1);
            chk("rst_out_data", i, 64'(od[i]), 64'd0);
            chk("rst_out_sat", i, 64'(os[i]), 64'd0);
            acc_m[i] = 0; first_m[i] = 1'b1; beat_m[i] = 0; sat_m[i] = 1'b0;
            took[i] = 1'b0;
            qd[i].delete(); qs[i].delete();
         end else begin
            automatic int sz = qd[i].size();
            automatic bit a  = iv[i] && (sz < DP[i]);
            automatic bit p  = (sz != 0) && ordy[i];
            chk("out_valid", i, 64'(ov[i]), 64'(sz != 0));
            chk("in_ready", i, 64'(ir[i]), 64'(sz < DP[i]));
            if (sz != 0) begin
               chk("out_data", i, 64'(od[i]), 64'(qd[i][0] & mask_of(i)));
               chk("out_sat", i, 64'(os[i]), 64'(qs[i][0]));
            end
            took[i] = a;
            if (p) begin
               logd[i].push_back(longint'(od[i]));
               logs[i].push_back(os[i]);
               void'(qd[i].pop_front());
               void'(qs[i].pop_front());
            end
            if (a) model_beat(i);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [15:0] s, input bit l);
      bit done = 1'b0;
      iv[i] = 1'b1; isum[i] = s; ilast[i] = l;
      for (int k = 0; k < 100 && !done; k++) begin
         cyc();
         done = took[i];
      end
      if (!done) begin
         nvec++; nerr++;
         $display("FAIL send_timeout dut%0d: beat %0h not accepted within 100 cycles", i, s);
      end
      iv[i] = 1'b0;
   endtask

   task automatic chk_log(input string nm, input int i, input int idx, input logic [63:0] want,
                          input bit want_sat);
      if (idx >= logd[i].size()) begin
         nvec++; nerr++;
         $display("FAIL %s dut%0d: result %0d missing, have %0d", nm, i, idx, logd[i].size());
      end else begin
         chk(nm, i, 64'(logd[i][idx]), want);
         chk({nm, "_sat"}, i, 64'(logs[i][idx]), 64'(want_sat));
      end
   endtask

   initial begin
      int n0;
      for (int i = 0; i < ND; i++) begin
         iv[i] = 1'b0; isum[i] = '0; ilast[i] = 1'b0; ordy[i] = 1'b1;
      end
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();

      // Basic fold: 3 - 1 + 7 + 2 = 11, valid exactly one cycle after the 4th beat.
      send(0, 16'd3, 0); send(0, 16'hFFFF, 0); send(0, 16'd7, 0);
      chk("fold_not_early", 0, 64'(ov[0]), 64'd0);
      send(0, 16'd2, 0);
      chk("fold_valid", 0, 64'(ov[0]), 64'd1);
      chk("fold_data", 0, 64'(od[0]), 64'd11);
      repeat (2) cyc();

      // Last-flag closing.
      send(1, 16'd5, 0); send(1, 16'd5, 0); send(1, 16'd5, 1); send(1, 16'd9, 1);
      repeat (3) cyc();
      chk_log("last_r0", 1, 0, 64'd15, 1'b0);
      chk_log("last_r1", 1, 1, 64'd9, 1'b0);

      // Back-pressure with a full FIFO.
      ordy[2] = 1'b0;
      for (int v = 1; v <= 4; v++) send(2, 16'(v), 0);
      iv[2] = 1'b1; isum[2] = 16'd5; ilast[2] = 1'b0;
      repeat (3) cyc();
      chk("full_in_ready", 2, 64'(ir[2]), 64'd0);
      chk("full_head", 2, 64'(od[2]), 64'd1);
      ordy[2] = 1'b1;
      cyc();
      chk("ready_after_pop", 2, 64'(ir[2]), 64'd1);
      send(2, 16'd5, 0); send(2, 16'd6, 0);
      repeat (8) cyc();
      for (int v = 1; v <= 6; v++) chk_log("bp_order", 2, v - 1, 64'(v), 1'b0);

      // Unsigned extension: 0xFFFF + 1 = 0x10000.
      send(3, 16'hFFFF, 0); send(3, 16'h0001, 0);
      repeat (2) cyc();
      chk_log("unsigned_ext", 3, 0, 64'h0001_0000, 1'b0);

      // Wrap versus saturation at 16 bits.
      send(4, 16'h7FFF, 0); send(4, 16'h0001, 0);
      repeat (2) cyc();
      if (SatEn) chk_log("sat_result", 4, 0, 64'h7FFF, 1'b1);
      else       chk_log("wrap_result", 4, 0, 64'h8000, 1'b0);

      // Reset with a partial sum and two queued results.
      ordy[0] = 1'b0;
      for (int k = 0; k < 8; k++) send(0, 16'd2, 0);
      send(0, 16'd10, 0); send(0, 16'd10, 0);
      chk("queued_before_rst", 0, 64'(ov[0]), 64'd1);
      n0 = logd[0].size();
      rst_n = 1'b0;
      #1;
      chk("rst_drops_valid", 0, 64'(ov[0]), 64'd0);
      cyc();
      rst_n = 1'b1;
      ordy[0] = 1'b1;
      cyc();
      for (int k = 0; k < 4; k++) send(0, 16'd1, 0);
      repeat (3) cyc();
      chk_log("post_reset", 0, n0, 64'd4, 1'b0);
      chk("post_reset_count", 0, 64'(logd[0].size()), 64'(n0 + 1));

      // Randomized traffic; a pending beat is held until accepted.
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < ND; i++) begin
            if (!(iv[i] && !took[i])) begin
               iv[i] = ($urandom_range(0, 9) < 7);
               case ($urandom_range(0, 4))
                  0: isum[i] = 16'h7FFF;
                  1: isum[i] = 16'h8000;
                  2: isum[i] = 16'hFFFF;
                  3: isum[i] = 16'($urandom_range(0, 15));
                  default: isum[i] = 16'($urandom);
               endcase
               ilast[i] = ($urandom_range(0, 9) < 3);
            end
            ordy[i] = ($urandom_range(0, 9) < 6);
         end
         if (c == 2000) rst_n = 1'b0;
         if (c == 2001) rst_n = 1'b1;
         cyc();
      end
      for (int i = 0; i < ND; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b1;
      end
      repeat (10) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
